// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and the oversampling-rate helper
// used by both the transmitter and the receiver.
package uart_pkg;

  localparam int unsigned OSR = 16;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

  // Clocks per oversample tick; clamped so an over-fast baud still yields a legal divider.
  function automatic int unsigned osr_div(input int unsigned clk_hz, input int unsigned baud);
    int unsigned div;
    div = clk_hz / (baud * OSR);
    return (div == 0) ? 1 : div;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs, with a configurable reset value
// so idle-high lines do not glitch low out of reset.
module sync_2ff #(
  parameter int unsigned           WIDTH   = 1,
  parameter logic [WIDTH-1:0]      RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 16x oversampling, start-glitch rejection, break handling
// and a valid/ready output register with overrun and framing-error pulses.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000,
  parameter int unsigned BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);

  localparam int unsigned OSR_DIV  = osr_div(CLK_HZ, BAUD);
  localparam logic [15:0] DIV_LAST = 16'(OSR_DIV - 1);

  logic        rxs;
  logic [15:0] div_cnt;
  logic        os_tick;

  rx_state_t   state, state_d;
  logic [3:0]  tickcnt, tickcnt_d;
  logic [2:0]  bitidx, bitidx_d;
  logic [7:0]  shreg, shreg_d;
  logic        byte_done;
  logic        stop_bad;

  sync_2ff #(
    .WIDTH   (1),
    .RST_VAL (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (rx),
    .q     (rxs)
  );

  // Free-running divider; deliberately not re-phased on the start edge.
  assign os_tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
    end else if (os_tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      tickcnt <= '0;
      bitidx  <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_d;
      tickcnt <= tickcnt_d;
      bitidx  <= bitidx_d;
      shreg   <= shreg_d;
    end
  end

  always_comb begin
    state_d   = state;
    tickcnt_d = tickcnt;
    bitidx_d  = bitidx;
    shreg_d   = shreg;
    byte_done = 1'b0;
    stop_bad  = 1'b0;

    unique case (state)
      IDLE: begin
        if (!rxs) begin
          state_d   = START;
          tickcnt_d = '0;
        end
      end

      START: begin
        if (os_tick) begin
          if (tickcnt == 4'd7) begin
            if (rxs) begin
              state_d = IDLE;
            end else begin
              state_d   = DATA;
              tickcnt_d = '0;
              bitidx_d  = '0;
            end
          end else begin
            tickcnt_d = tickcnt + 4'd1;
          end
        end
      end

      // tickcnt wraps 15 -> 0, so each bit period restarts without an explicit clear.
      DATA: begin
        if (os_tick) begin
          tickcnt_d = tickcnt + 4'd1;
          if (tickcnt == 4'd15) begin
            shreg_d[bitidx] = rxs;
            if (bitidx == 3'd7) begin
              state_d = STOP;
            end else begin
              bitidx_d = bitidx + 3'd1;
            end
          end
        end
      end

      STOP: begin
        if (os_tick) begin
          tickcnt_d = tickcnt + 4'd1;
          if (tickcnt == 4'd15) begin
            if (rxs) begin
              byte_done = 1'b1;
              state_d   = IDLE;
            end else begin
              stop_bad = 1'b1;
              state_d  = BREAK;
            end
          end
        end
      end

      BREAK: begin
        if (rxs) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // A completion that coincides with acceptance reloads, so valid stays high without a gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= byte_done && valid && !ready;
      if (byte_done) begin
        if (!valid || ready) begin
          data  <= shreg;
          valid <= 1'b1;
        end
      end else if (valid && ready) begin
        valid <= 1'b0;
      end
    end
  end

endmodule
